config_frame_loader: RTL and testbench

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

---
 rtl/cfg_pkg.sv | 25 ++
 rtl/cfg_shift_reg.sv | 45 ++++
 rtl/config_frame_loader.sv | 129 ++++++++++++
 tb/tb_config_frame_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// cfg_pkg : shared state encoding and default sizes for the frame loader
// Rev 1.0
// ============================================================================
package cfg_pkg;

   localparam int c_addr_bits  = 4;
   localparam int c_num_blocks = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } cfg_state_t;

   // A counter for n terminal values never needs fewer than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_shift_reg.sv
`default_nettype none
// ============================================================================
// cfg_shift_reg : serial-in / parallel-out frame register, MSB-first fill
// Rev 1.0
// ============================================================================
module cfg_shift_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_shift_en,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   generate
      if (WIDTH == 1) begin : g_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_data <= '0;
            else if (i_clr)
               r_data <= '0;
            else if (i_shift_en)
               r_data <= i_bit;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_data <= '0;
            else if (i_clr)
               r_data <= '0;
            else if (i_shift_en)
               r_data <= {r_data[WIDTH-2:0], i_bit};
         end
      end
   endgenerate

   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/config_frame_loader.sv
`default_nettype none
// ============================================================================
// config_frame_loader : loads NUM_BLOCKS serial frames into latch blocks
// Rev 1.0
// ============================================================================
module config_frame_loader
   import cfg_pkg::*;
#(
   parameter int ADDR_BITS  = c_addr_bits,
   parameter int MEM_SIZE   = 2**ADDR_BITS,
   parameter int NUM_BLOCKS = c_num_blocks
) (
   input  logic                  cclk,
   input  logic                  crst_n,
   input  logic                  cfg_start,
   input  logic                  cfg_abort,
   input  logic                  cfg_bit,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic [MEM_SIZE-1:0]   config_out,
   output logic [NUM_BLOCKS-1:0] cen_out,
   output logic                  busy,
   output logic                  done
);

   localparam int c_bit_w = cnt_width(MEM_SIZE);
   localparam int c_blk_w = cnt_width(NUM_BLOCKS);
   localparam logic [c_bit_w-1:0]    c_last_bit = c_bit_w'(MEM_SIZE - 1);
   localparam logic [c_blk_w-1:0]    c_last_blk = c_blk_w'(NUM_BLOCKS - 1);
   localparam logic [NUM_BLOCKS-1:0] c_cen_one  = NUM_BLOCKS'(1);

   cfg_state_t          r_state;
   logic [c_bit_w-1:0]  r_bit_cnt;
   logic [c_blk_w-1:0]  r_blk_cnt;
   logic                r_cfg_ready;
   logic                r_busy;
   logic                r_done;
   logic [NUM_BLOCKS-1:0] r_cen;

   logic w_shift_en;
   logic w_clr;

   // r_cfg_ready is high exactly in SHIFT; abort wins over a coincident bit.
   assign w_shift_en = r_cfg_ready & cfg_valid & ~cfg_abort;
   assign w_clr      = cfg_abort & ((r_state == ST_SHIFT) | (r_state == ST_WRITE));

   cfg_shift_reg #(
      .WIDTH (MEM_SIZE)
   ) u_shift (
      .clk        (cclk),
      .rst_n      (crst_n),
      .i_clr      (w_clr),
      .i_shift_en (w_shift_en),
      .i_bit      (cfg_bit),
      .o_data     (config_out)
   );

   always_ff @(posedge cclk or negedge crst_n) begin
      if (!crst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_blk_cnt   <= '0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cen       <= '0;
      end else begin
         r_cen  <= '0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_start) begin
                  r_state     <= ST_SHIFT;
                  r_bit_cnt   <= '0;
                  r_blk_cnt   <= '0;
                  r_cfg_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cfg_abort) begin
                  r_state     <= ST_IDLE;
                  r_cfg_ready <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (cfg_valid) begin
                  if (r_bit_cnt == c_last_bit) begin
                     r_state     <= ST_WRITE;
                     r_cfg_ready <= 1'b0;
                     r_cen       <= c_cen_one << r_blk_cnt;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (cfg_abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_blk_cnt == c_last_blk) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= ST_SHIFT;
                  r_blk_cnt   <= r_blk_cnt + 1'b1;
                  r_bit_cnt   <= '0;
                  r_cfg_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cfg_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cen_out   = r_cen;

endmodule

`default_nettype wire

// File: tb/tb_config_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_config_frame_loader : directed + randomized check of the frame loader
// Rev 1.0
// ============================================================================
module tb_config_frame_loader;

   localparam int MEM = 16;
   localparam int NB  = 4;

   logic          cclk = 1'b0;
   logic          crst_n = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_abort = 1'b0;
   logic          cfg_bit = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [MEM-1:0] config_out;
   logic [NB-1:0] cen_out;
   logic          busy;
   logic          done;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference view: expected frame register contents, and whether it is known.
   logic [MEM-1:0] m_out = '0;
   bit             m_known = 1'b1;

   config_frame_loader #(
      .ADDR_BITS  (4),
      .MEM_SIZE   (MEM),
      .NUM_BLOCKS (NB)
   ) dut (
      .cclk       (cclk),
      .crst_n     (crst_n),
      .cfg_start  (cfg_start),
      .cfg_abort  (cfg_abort),
      .cfg_bit    (cfg_bit),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .config_out (config_out),
      .cen_out    (cen_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 cclk = ~cclk;

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic r, input logic b, input logic d,
                          input logic [NB-1:0] c);
      chk({tag, ".ready"}, 32'(cfg_ready), 32'(r));
      chk({tag, ".busy"},  32'(busy),      32'(b));
      chk({tag, ".done"},  32'(done),      32'(d));
      chk({tag, ".cen"},   32'(cen_out),   32'(c));
      if (m_known)
         chk({tag, ".cfg"}, 32'(config_out), 32'(m_out));
   endtask

   // Idle with stray valid data (must not be consumed), then a start pulse.
   task automatic start_session();
      cfg_start = 1'b0;
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      tick();
      chk_ctl("idle", 1'b0, 1'b0, 1'b0, '0);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      chk_ctl("start", 1'b1, 1'b1, 1'b0, '0);
   endtask

   // Sends the top `bits` bits of f MSB first. gap<0: one stall before each bit;
   // gap>0: random stalls up to gap. Stray start pulses are mixed in.
   task automatic send_frame(input logic [MEM-1:0] f, input int gap, input int bits,
                             output int cyc);
      cyc = 0;
      for (int i = MEM - 1; i >= MEM - bits; i--) begin
         int idle;
         idle = (gap < 0) ? 1 : ((gap == 0) ? 0 : int'($urandom_range(0, gap)));
         repeat (idle) begin
            cfg_valid = 1'b0;
            cfg_bit   = 1'($urandom);
            cfg_start = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
            chk_ctl("stall", 1'b1, 1'b1, 1'b0, '0);
         end
         cfg_valid = 1'b1;
         cfg_bit   = f[i];
         cfg_start = ($urandom_range(0, 3) == 0);
         tick();
         cyc++;
         m_out = {m_out[MEM-2:0], f[i]};
         if (i != 0)
            chk_ctl("shift", 1'b1, 1'b1, 1'b0, '0);
      end
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
   endtask

   // Called one cycle after the last bit of frame f for block blk.
   task automatic finish_frame(input logic [MEM-1:0] f, input int blk);
      m_out   = f;
      m_known = 1'b1;
      chk_ctl("write", 1'b0, 1'b1, 1'b0, NB'(1 << blk));
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      cfg_start = 1'($urandom);
      tick();
      if (blk == NB - 1) begin
         chk_ctl("done", 1'b0, 1'b1, 1'b1, '0);
         tick();
         cfg_start = 1'b0;
         chk_ctl("end", 1'b0, 1'b0, 1'b0, '0);
      end else begin
         chk_ctl("next", 1'b1, 1'b1, 1'b0, '0);
      end
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
   endtask

   task automatic full_session(input logic [MEM-1:0] fr [NB], input int gap);
      int cyc;
      start_session();
      for (int b = 0; b < NB; b++) begin
         send_frame(fr[b], gap, MEM, cyc);
         if (gap == 0)
            chk("b2b_cycles", 32'(cyc), 32'(MEM));
         finish_frame(fr[b], b);
      end
   endtask

   task automatic abort_now(input string tag);
      cfg_abort = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom);
      tick();
      cfg_abort = 1'b0;
      cfg_valid = 1'b0;
      m_known   = 1'b0;
      chk_ctl(tag, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [MEM-1:0] fr [NB];
      int cyc;

      // Reset state.
      tick();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, '0);
      crst_n = 1'b1;
      tick();
      chk_ctl("post_reset", 1'b0, 1'b0, 1'b0, '0);

      // Back-to-back directed session.
      fr = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
      full_session(fr, 0);

      // Half-rate valid: WRITE visible 2*MEM cycles after SHIFT entry.
      start_session();
      send_frame(16'h8001, -1, MEM, cyc);
      chk("half_rate_cycles", 32'(cyc), 32'(2 * MEM));
      finish_frame(16'h8001, 0);
      abort_now("abort_blk1_start");

      // Abort after 7 bits of block 2; cen[2] and done must never appear.
      start_session();
      for (int b = 0; b < 2; b++) begin
         fr[b] = 16'($urandom);
         send_frame(fr[b], 1, MEM, cyc);
         finish_frame(fr[b], b);
      end
      send_frame(16'($urandom), 0, 7, cyc);
      abort_now("abort_mid");
      repeat (4) begin
         cfg_valid = 1'($urandom);
         tick();
         chk_ctl("after_abort", 1'b0, 1'b0, 1'b0, '0);
      end
      cfg_valid = 1'b0;

      // Abort coinciding with the last bit beats the move to WRITE.
      start_session();
      send_frame(16'($urandom), 0, MEM - 1, cyc);
      abort_now("abort_last_bit");

      // Abort during WRITE.
      start_session();
      fr[0] = 16'($urandom);
      send_frame(fr[0], 0, MEM, cyc);
      m_out   = fr[0];
      m_known = 1'b1;
      chk_ctl("write_pre_abort", 1'b0, 1'b1, 1'b0, 4'b0001);
      abort_now("abort_write");

      // Asynchronous reset in the middle of frame 1.
      start_session();
      fr[0] = 16'($urandom);
      send_frame(fr[0], 0, MEM, cyc);
      finish_frame(fr[0], 0);
      send_frame(16'($urandom), 0, 5, cyc);
      #3;
      crst_n = 1'b0;
      #1;
      m_out   = '0;
      m_known = 1'b1;
      chk_ctl("async_reset", 1'b0, 1'b0, 1'b0, '0);
      tick();
      chk_ctl("reset_held", 1'b0, 1'b0, 1'b0, '0);
      crst_n    = 1'b1;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk_ctl("start_on_release", 1'b1, 1'b1, 1'b0, '0);
      for (int b = 0; b < NB; b++) begin
         fr[b] = 16'($urandom);
         send_frame(fr[b], 2, MEM, cyc);
         finish_frame(fr[b], b);
      end

      // Randomized sessions.
      repeat (3) begin
         for (int b = 0; b < NB; b++)
            fr[b] = 16'($urandom);
         full_session(fr, 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
